// File: rtl/nonce_search_engine.sv
// Nonce search engine: walks candidate nonces, mixes each with a fixed header
// through an add-rotate-xor mixer and halts on the first leading-zero digest.
module nonce_search_engine #(
  parameter logic [31:0] NONCE_START      = 32'h0000_0000,
  parameter logic [31:0] NONCE_STEP       = 32'h0000_0001,
  parameter logic [63:0] HEADER           = 64'h0123_4567_89AB_CDEF,
  parameter int          ROUNDS           = 8,
  parameter int          TARGET_ZERO_BITS = 8
) (
  input  logic        osc_clk,
  input  logic        reset,
  output logic [31:0] nonce,
  output logic [43:0] padded_nonce
);

  // state   | meaning
  // S_LOAD  | seed mixer from header and current nonce
  // S_HASH  | one mixer round per cycle, ROUNDS cycles
  // S_CHECK | test digest against leading-zero target, advance nonce on miss
  // S_FOUND | winning nonce held until reset
  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_HASH  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_FOUND = 2'd3;

  localparam logic [5:0] RC_LAST = 6'(ROUNDS - 1);

  // Top TARGET_ZERO_BITS of the digest must be zero; an empty mask always hits.
  localparam logic [31:0] ZERO_MASK =
    (TARGET_ZERO_BITS == 0) ? 32'h0 : ~(32'hFFFF_FFFF >> TARGET_ZERO_BITS);

  logic [1:0]  r_state;
  logic [31:0] r_nonce;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [5:0]  r_rc;

  logic [31:0] w_a_next;
  logic [31:0] w_b_next;
  logic [31:0] w_digest;
  logic        w_hit;

  assign w_a_next = r_a + r_b;
  assign w_b_next = {r_b[26:0], r_b[31:27]} ^ w_a_next;
  assign w_digest = r_a ^ r_b;
  assign w_hit    = ((w_digest & ZERO_MASK) == 32'h0);

  always_ff @(posedge osc_clk) begin
    if (!reset) begin
      r_state <= S_LOAD;
      r_nonce <= NONCE_START;
      r_a     <= 32'h0;
      r_b     <= 32'h0;
      r_rc    <= 6'd0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_a     <= HEADER[63:32];
          r_b     <= HEADER[31:0] ^ r_nonce;
          r_rc    <= 6'd0;
          r_state <= S_HASH;
        end
        S_HASH: begin
          r_a  <= w_a_next;
          r_b  <= w_b_next;
          r_rc <= r_rc + 6'd1;
          if (r_rc == RC_LAST) r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_hit) begin
            r_state <= S_FOUND;
          end else begin
            r_nonce <= r_nonce + NONCE_STEP;
            r_state <= S_LOAD;
          end
        end
        S_FOUND: r_state <= S_FOUND;
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign nonce        = r_nonce;
  assign padded_nonce = {r_nonce, 12'h800};

endmodule

// File: tb/tb_nonce_search_engine.sv
// Bench for nonce_search_engine: three parameterisations share one clock and are
// compared every cycle against a candidate-level reference model.
module tb_nonce_search_engine;

  localparam logic [63:0] HDR       = 64'h0123_4567_89AB_CDEF;
  localparam int          RNDS      = 8;
  localparam int          PERIOD    = RNDS + 2;
  localparam logic [31:0] DEF_START = 32'h0;
  localparam logic [31:0] HIT_START = 32'h1234;
  localparam logic [31:0] WRP_START = 32'hFFFF_FFFF;
  localparam logic [31:0] STEP      = 32'h1;

  logic        clk = 1'b0;
  logic        rst_def = 1'b0, rst_hit = 1'b0, rst_wrp = 1'b0;
  logic [31:0] n_def, n_hit, n_wrp;
  logic [43:0] p_def, p_hit, p_wrp;

  int checks = 0;
  int failures = 0;
  int hidx_def, hidx_hit, hidx_wrp;

  always #5 clk = ~clk;

  nonce_search_engine u_def (
    .osc_clk(clk), .reset(rst_def), .nonce(n_def), .padded_nonce(p_def));

  nonce_search_engine #(.NONCE_START(HIT_START), .TARGET_ZERO_BITS(0)) u_hit (
    .osc_clk(clk), .reset(rst_hit), .nonce(n_hit), .padded_nonce(p_hit));

  nonce_search_engine #(.NONCE_START(WRP_START), .TARGET_ZERO_BITS(32)) u_wrp (
    .osc_clk(clk), .reset(rst_wrp), .nonce(n_wrp), .padded_nonce(p_wrp));

  // Digest of one candidate: the ARX recurrence written as plain arithmetic.
  function automatic logic [31:0] model_digest(input logic [31:0] n);
    logic [31:0] a, b;
    a = HDR[63:32];
    b = HDR[31:0] ^ n;
    for (int r = 0; r < RNDS; r++) begin
      a = a + b;
      b = ((b << 5) | (b >> 27)) ^ a;
    end
    return a ^ b;
  endfunction

  function automatic bit model_hit(input logic [31:0] n, input int tzb);
    logic [31:0] d;
    d = model_digest(n);
    if (tzb == 0) return 1'b1;
    return ((d >> (32 - tzb)) == 32'h0);
  endfunction

  // Index of the first winning candidate, or limit if none within limit.
  function automatic int first_hit(input logic [31:0] start, input int tzb, input int limit);
    for (int i = 0; i < limit; i++)
      if (model_hit(start + STEP * 32'(i), tzb)) return i;
    return limit;
  endfunction

  // Nonce after k rising edges since reset release.
  function automatic logic [31:0] exp_nonce(input logic [31:0] start, input int hidx, input int k);
    int c;
    c = k / PERIOD;
    if (c > hidx) c = hidx;
    return start + STEP * 32'(c);
  endfunction

  task automatic test_reset();
    rst_def = 1'b0; rst_hit = 1'b0; rst_wrp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (n_def !== 32'h0) begin
      failures++; $display("FAIL reset_nonce got=%h exp=%h", n_def, 32'h0);
    end
    checks++;
    if (p_def !== 44'h000_0000_0800) begin
      failures++; $display("FAIL reset_padded got=%h exp=%h", p_def, 44'h000_0000_0800);
    end
    checks++;
    if (n_hit !== HIT_START) begin
      failures++; $display("FAIL reset_hit_nonce got=%h exp=%h", n_hit, HIT_START);
    end
    checks++;
    if (p_wrp !== {WRP_START, 12'h800}) begin
      failures++; $display("FAIL reset_wrap_padded got=%h exp=%h", p_wrp, {WRP_START, 12'h800});
    end
  endtask

  task automatic test_cadence();
    logic [31:0] e;
    rst_def = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      e = exp_nonce(DEF_START, hidx_def, k);
      checks++;
      if (n_def !== e) begin
        failures++; $display("FAIL cadence_nonce k=%0d got=%h exp=%h", k, n_def, e);
      end
      checks++;
      if (p_def !== {e, 12'h800}) begin
        failures++; $display("FAIL cadence_padded k=%0d got=%h exp=%h", k, p_def, {e, 12'h800});
      end
    end
  endtask

  task automatic test_immediate_hit();
    logic [31:0] e;
    @(negedge clk);
    rst_hit = 1'b1;
    for (int k = 1; k <= 1010; k++) begin
      @(negedge clk);
      e = exp_nonce(HIT_START, hidx_hit, k);
      checks++;
      if (n_hit !== e) begin
        failures++; $display("FAIL hit_hold k=%0d got=%h exp=%h", k, n_hit, e);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    @(negedge clk);
    rst_wrp = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      e = exp_nonce(WRP_START, hidx_wrp, k);
      checks++;
      if (n_wrp !== e) begin
        failures++; $display("FAIL wrap_nonce k=%0d got=%h exp=%h", k, n_wrp, e);
      end
      checks++;
      if (p_wrp !== {e, 12'h800}) begin
        failures++; $display("FAIL wrap_padded k=%0d got=%h exp=%h", k, p_wrp, {e, 12'h800});
      end
    end
    rst_wrp = 1'b0;
    @(negedge clk);
    checks++;
    if (n_wrp !== WRP_START) begin
      failures++; $display("FAIL wrap_rearm got=%h exp=%h", n_wrp, WRP_START);
    end
  endtask

  task automatic test_reset_mid_hash();
    logic [31:0] e;
    int abort_at;
    for (int t = 0; t < 5; t++) begin
      rst_def = 1'b0;
      @(negedge clk);
      rst_def = 1'b1;
      abort_at = (t == 0) ? 25 : int'($urandom_range(11, 45));
      for (int k = 1; k <= abort_at; k++) begin
        @(negedge clk);
        e = exp_nonce(DEF_START, hidx_def, k);
        checks++;
        if (n_def !== e) begin
          failures++; $display("FAIL midrst_pre t=%0d k=%0d got=%h exp=%h", t, k, n_def, e);
        end
      end
      rst_def = 1'b0;
      @(negedge clk);
      checks++;
      if (n_def !== DEF_START) begin
        failures++; $display("FAIL midrst_restart t=%0d got=%h exp=%h", t, n_def, DEF_START);
      end
      rst_def = 1'b1;
      for (int k = 1; k <= 25; k++) begin
        @(negedge clk);
        e = exp_nonce(DEF_START, hidx_def, k);
        checks++;
        if (n_def !== e) begin
          failures++; $display("FAIL midrst_post t=%0d k=%0d got=%h exp=%h", t, k, n_def, e);
        end
      end
    end
  endtask

  task automatic test_long_run();
    logic [31:0] e;
    rst_def = 1'b0;
    @(negedge clk);
    rst_def = 1'b1;
    for (int k = 1; k <= 10000; k++) begin
      @(negedge clk);
      e = exp_nonce(DEF_START, hidx_def, k);
      checks++;
      if (n_def !== e) begin
        failures++; $display("FAIL long_nonce k=%0d got=%h exp=%h", k, n_def, e);
      end
      checks++;
      if (p_def !== {e, 12'h800}) begin
        failures++; $display("FAIL long_padded k=%0d got=%h exp=%h", k, p_def, {e, 12'h800});
      end
    end
  endtask

  initial begin
    hidx_def = first_hit(DEF_START, 8, 10000 / PERIOD + 1);
    hidx_hit = first_hit(HIT_START, 0, 200);
    hidx_wrp = first_hit(WRP_START, 32, 10);
    test_reset();
    test_cadence();
    test_immediate_hit();
    test_wrap();
    test_reset_mid_hash();
    test_long_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
